// File: rtl/mips_mc_ctrl_hs.sv
// Multicycle MIPS control unit with a req/ready memory handshake.
// Drives the standard multicycle datapath and aludec. Memory states
// (FETCH, MEMRD, MEMWR) hold mem_req until mem_ready, guarded by a
// wait-cycle watchdog. Illegal opcodes and bus timeouts park the FSM in a
// sticky FAULT state that only reset leaves. instr_count counts retired
// instructions.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   op, funct, zero     instruction fields and ALU zero flag
//   mem_ready           memory completes the current request this cycle
//   mem_req, memwrite   memory request and write strobe
//   pcen ... aluop      datapath controls
//   fault, fault_code   sticky fault flag and cause (01 illegal, 10 timeout)
//   state_o             current state (debug)
//   instr_count         retired-instruction counter
module mips_mc_ctrl_hs #(
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             memwrite,
  output logic             pcen,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic             jal,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [4:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [4:0] {
    FETCH   = 5'd0,  DECODE  = 5'd1,  MEMADR  = 5'd2,  MEMRD   = 5'd3,
    MEMWB   = 5'd4,  MEMWR   = 5'd5,  RTYPEEX = 5'd6,  RTYPEWB = 5'd7,
    BEQEX   = 5'd8,  ADDIEX  = 5'd9,  IWB     = 5'd10, JEX     = 5'd11,
    BNEEX   = 5'd12, ORIEX   = 5'd13, JALEX   = 5'd14, JREX    = 5'd15,
    FAULT   = 5'd31
  } state_t;

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_t            state, state_n;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        code_n;
  logic              mem_state, timeout, stall, req_dec;

  assign mem_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign timeout   = mem_state && !mem_ready && (wait_cnt == MAX_WAIT_C);
  assign stall     = mem_state && !mem_ready && !timeout;

  // Reset kills the request combinationally so a pending access is dropped
  // the instant reset rises, not at the next edge.
  assign mem_req = req_dec & ~reset;
  assign state_o = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  // Any cycle that is not a stall either leaves the memory state or is not
  // a memory state, so clearing here gives a fresh count on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      wait_cnt <= '0;
    else if (stall) wait_cnt <= wait_cnt + 1'b1;
    else            wait_cnt <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else if (state != FAULT && state_n == FAULT) begin
      fault      <= 1'b1;
      fault_code <= code_n;
    end
  end

  // Only terminal states ever branch to FETCH, so this is the retire point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      instr_count <= '0;
    else if (state != FETCH && state != FAULT && state_n == FETCH)
      instr_count <= instr_count + 1'b1;
  end

  always_comb begin
    state_n  = state;
    code_n   = 2'b00;
    req_dec  = 1'b0;
    memwrite = 1'b0;
    pcen     = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    jal      = 1'b0;
    pcsrc    = 2'b00;
    alusrcb  = 3'b000;
    aluop    = 2'b00;
    case (state)
      FETCH: begin
        req_dec = 1'b1;
        alusrcb = 3'b001;
        irwrite = mem_ready;
        pcen    = mem_ready;
        if (mem_ready)    state_n = DECODE;
        else if (timeout) begin state_n = FAULT; code_n = 2'b10; end
      end
      DECODE: begin
        alusrcb = 3'b011;
        case (op)
          6'b100011, 6'b101011: state_n = MEMADR;
          6'b000000: state_n = (funct == 6'b001000) ? JREX : RTYPEEX;
          6'b000100: state_n = BEQEX;
          6'b000101: state_n = BNEEX;
          6'b001000: state_n = ADDIEX;
          6'b001101: state_n = ORIEX;
          6'b000010: state_n = JEX;
          6'b000011: state_n = JALEX;
          default: begin state_n = FAULT; code_n = 2'b01; end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 3'b010;
        state_n = (op == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        req_dec = 1'b1;
        iord    = 1'b1;
        if (mem_ready)    state_n = MEMWB;
        else if (timeout) begin state_n = FAULT; code_n = 2'b10; end
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_n  = FETCH;
      end
      MEMWR: begin
        req_dec  = 1'b1;
        iord     = 1'b1;
        memwrite = mem_ready;
        if (mem_ready)    state_n = FETCH;
        else if (timeout) begin state_n = FAULT; code_n = 2'b10; end
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_n = RTYPEWB;
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_n  = FETCH;
      end
      BEQEX, BNEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        pcen    = (state == BEQEX) ? zero : ~zero;
        state_n = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 3'b010;
        state_n = IWB;
      end
      ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 3'b100;
        aluop   = 2'b11;
        state_n = IWB;
      end
      IWB: begin
        regwrite = 1'b1;
        state_n  = FETCH;
      end
      JEX: begin
        pcen    = 1'b1;
        pcsrc   = 2'b10;
        state_n = FETCH;
      end
      JALEX: begin
        pcen     = 1'b1;
        pcsrc    = 2'b10;
        regwrite = 1'b1;
        jal      = 1'b1;
        state_n  = FETCH;
      end
      JREX: begin
        pcen    = 1'b1;
        pcsrc   = 2'b11;
        state_n = FETCH;
      end
      FAULT:   state_n = FAULT;
      default: state_n = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_ctrl_hs.sv
module tb_mips_mc_ctrl_hs;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, memwrite, pcen, irwrite, regwrite, alusrca, iord;
  logic       memtoreg, regdst, jal, fault;
  logic [1:0] pcsrc, aluop, fault_code;
  logic [2:0] alusrcb;
  logic [4:0] state_o;
  logic [3:0] instr_count;

  int total = 0;
  int bad = 0;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_J = 6'b000010, OP_JAL = 6'b000011;

  mips_mc_ctrl_hs #(.WAIT_W(8), .MAX_WAIT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
    .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .jal(jal),
    .pcsrc(pcsrc), .alusrcb(alusrcb), .aluop(aluop), .fault(fault),
    .fault_code(fault_code), .state_o(state_o), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Runs one instruction starting at a negedge in its first FETCH cycle.
  // A responsive memory raises mem_ready after fw (fetch) / mw (data) waits.
  // Returns at the negedge where FETCH (or FAULT) is reached again.
  task automatic exec(input logic [5:0] o, input logic [5:0] f, input logic z,
                      input int fw, input int mw, output int cyc, output int pc_n,
                      output int ir_n, output int mwr_n, output int mwr_rdy,
                      output int rw_n);
    int wcnt, phase;
    bit left, done, rdy;
    cyc = 0; pc_n = 0; ir_n = 0; mwr_n = 0; mwr_rdy = 0; rw_n = 0;
    wcnt = 0; phase = 0; left = 0; done = 0;
    op = o; funct = f; zero = z;
    while (!done) begin
      if (left && (state_o == 5'd0 || state_o == 5'd31)) done = 1;
      else if (cyc >= 200) done = 1;
      else begin
        if (state_o != 5'd0) left = 1;
        rdy = mem_req && (wcnt == ((phase == 0) ? fw : mw));
        mem_ready = rdy;
        #1;
        pc_n += int'(pcen);
        ir_n += int'(irwrite);
        mwr_n += int'(memwrite);
        rw_n += int'(regwrite);
        if (memwrite && mem_ready) mwr_rdy++;
        if (mem_req) begin
          if (rdy) begin wcnt = 0; phase++; end
          else wcnt++;
        end
        cyc++;
        @(negedge clk);
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (state_o !== 5'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", state_o); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    total++; if (instr_count !== 4'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", instr_count); end
    total++; if ({fault, fault_code} !== 3'b000) begin bad++; $display("FAIL rst_fault: got %b want 000", {fault, fault_code}); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (mem_req !== 1'b1 || alusrcb !== 3'b001) begin bad++; $display("FAIL rel_fetch: got req=%b srcb=%b want 1 001", mem_req, alusrcb); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_zero_wait();
    int c, p, i, w, r, rw;
    exec(OP_ADDI, 6'd0, 1'b0, 0, 0, c, p, i, w, r, rw);
    total++; if (c != 4 || p != 1 || i != 1 || rw != 1) begin bad++; $display("FAIL zw_addi: got cyc=%0d pc=%0d ir=%0d rw=%0d want 4 1 1 1", c, p, i, rw); end
    exec(OP_SW, 6'd0, 1'b0, 0, 0, c, p, i, w, r, rw);
    total++; if (c != 4 || p != 1 || w != 1 || r != 1 || rw != 0) begin bad++; $display("FAIL zw_sw: got cyc=%0d pc=%0d mw=%0d rdy=%0d rw=%0d want 4 1 1 1 0", c, p, w, r, rw); end
    exec(OP_LW, 6'd0, 1'b0, 0, 0, c, p, i, w, r, rw);
    total++; if (c != 5 || p != 1 || w != 0 || rw != 1) begin bad++; $display("FAIL zw_lw: got cyc=%0d pc=%0d mw=%0d rw=%0d want 5 1 0 1", c, p, w, rw); end
    exec(OP_BEQ, 6'd0, 1'b1, 0, 0, c, p, i, w, r, rw);
    total++; if (c != 3 || p != 2 || i != 1) begin bad++; $display("FAIL zw_beq: got cyc=%0d pc=%0d ir=%0d want 3 2 1", c, p, i); end
    exec(OP_JAL, 6'd0, 1'b0, 0, 0, c, p, i, w, r, rw);
    total++; if (c != 3 || p != 2 || rw != 1) begin bad++; $display("FAIL zw_jal: got cyc=%0d pc=%0d rw=%0d want 3 2 1", c, p, rw); end
    total++; if (instr_count !== 4'd5) begin bad++; $display("FAIL zw_count: got %0d want 5", instr_count); end
  endtask

  task automatic test_fetch_wait();
    op = OP_ADDI; funct = 6'd0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      #1;
      total++; if (mem_req !== 1'b1 || state_o !== 5'd0) begin bad++; $display("FAIL fw_req%0d: got req=%b st=%0d want 1 0", k, mem_req, state_o); end
      total++; if (irwrite !== (k == 3) || pcen !== (k == 3)) begin bad++; $display("FAIL fw_en%0d: got ir=%b pc=%b want %b", k, irwrite, pcen, k == 3); end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1;
    total++; if (state_o !== 5'd1 || alusrcb !== 3'b011 || mem_req !== 1'b0) begin bad++; $display("FAIL fw_decode: got st=%0d srcb=%b req=%b want 1 011 0", state_o, alusrcb, mem_req); end
    @(negedge clk);
    #1;
    total++; if (state_o !== 5'd9 || alusrca !== 1'b1 || alusrcb !== 3'b010) begin bad++; $display("FAIL fw_addiex: got st=%0d a=%b b=%b want 9 1 010", state_o, alusrca, alusrcb); end
    @(negedge clk);
    #1;
    total++; if (state_o !== 5'd10 || regwrite !== 1'b1) begin bad++; $display("FAIL fw_iwb: got st=%0d rw=%b want 10 1", state_o, regwrite); end
    @(negedge clk);
    total++; if (state_o !== 5'd0 || instr_count !== 4'd6) begin bad++; $display("FAIL fw_retire: got st=%0d cnt=%0d want 0 6", state_o, instr_count); end
  endtask

  task automatic test_sw_wait();
    int c, p, i, w, r, rw;
    exec(OP_SW, 6'd0, 1'b0, 0, 2, c, p, i, w, r, rw);
    total++; if (c != 6 || w != 1 || r != 1) begin bad++; $display("FAIL sw_wait: got cyc=%0d mw=%0d coincident=%0d want 6 1 1", c, w, r); end
    total++; if (instr_count !== 4'd7) begin bad++; $display("FAIL sw_count: got %0d want 7", instr_count); end
  endtask

  task automatic test_other_ops();
    int c, p, i, w, r, rw;
    exec(OP_R, 6'b100000, 1'b0, 0, 0, c, p, i, w, r, rw);
    total++; if (c != 4 || rw != 1) begin bad++; $display("FAIL rtype: got cyc=%0d rw=%0d want 4 1", c, rw); end
    exec(OP_ORI, 6'd0, 1'b0, 0, 0, c, p, i, w, r, rw);
    total++; if (c != 4 || rw != 1) begin bad++; $display("FAIL ori: got cyc=%0d rw=%0d want 4 1", c, rw); end
    exec(OP_BNE, 6'd0, 1'b1, 0, 0, c, p, i, w, r, rw);
    total++; if (c != 3 || p != 1) begin bad++; $display("FAIL bne_z1: got cyc=%0d pc=%0d want 3 1", c, p); end
    exec(OP_BNE, 6'd0, 1'b0, 0, 0, c, p, i, w, r, rw);
    total++; if (c != 3 || p != 2) begin bad++; $display("FAIL bne_z0: got cyc=%0d pc=%0d want 3 2", c, p); end
    op = OP_R; funct = 6'b001000; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    total++; if (state_o !== 5'd15 || pcsrc !== 2'b11 || pcen !== 1'b1) begin bad++; $display("FAIL jr: got st=%0d pcsrc=%b pcen=%b want 15 11 1", state_o, pcsrc, pcen); end
    @(negedge clk);
    total++; if (state_o !== 5'd0 || instr_count !== 4'd12) begin bad++; $display("FAIL jr_retire: got st=%0d cnt=%0d want 0 12", state_o, instr_count); end
  endtask

  task automatic test_reset_mid_wait();
    op = OP_LW; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (state_o !== 5'd3 || mem_req !== 1'b1) begin bad++; $display("FAIL mid_memrd: got st=%0d req=%b want 3 1", state_o, mem_req); end
    reset = 1'b1;
    #1;
    total++; if (state_o !== 5'd0 || mem_req !== 1'b0 || instr_count !== 4'd0) begin bad++; $display("FAIL mid_reset: got st=%0d req=%b cnt=%0d want 0 0 0", state_o, mem_req, instr_count); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int c, p, i, w, r, rw;
    exec(OP_LW, 6'd0, 1'b0, 0, 4, c, p, i, w, r, rw);
    total++; if (c != 9 || state_o !== 5'd0 || fault !== 1'b0) begin bad++; $display("FAIL to_boundary: got cyc=%0d st=%0d fault=%b want 9 0 0", c, state_o, fault); end
    exec(OP_LW, 6'd0, 1'b0, 0, 50, c, p, i, w, r, rw);
    #1;
    total++; if (c != 8 || state_o !== 5'd31) begin bad++; $display("FAIL to_enter: got cyc=%0d st=%0d want 8 31", c, state_o); end
    total++; if (fault !== 1'b1 || fault_code !== 2'b10 || mem_req !== 1'b0) begin bad++; $display("FAIL to_flags: got f=%b code=%b req=%b want 1 10 0", fault, fault_code, mem_req); end
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (state_o !== 5'd31 || instr_count !== 4'd1 || pcen !== 1'b0 || regwrite !== 1'b0) begin bad++; $display("FAIL to_hold: got st=%0d cnt=%0d pcen=%b rw=%b want 31 1 0 0", state_o, instr_count, pcen, regwrite); end
    mem_ready = 1'b0;
    apply_reset();
  endtask

  task automatic test_illegal();
    int c, p, i, w, r, rw;
    exec(6'b111111, 6'd0, 1'b0, 0, 0, c, p, i, w, r, rw);
    #1;
    total++; if (c != 2 || state_o !== 5'd31 || fault !== 1'b1 || fault_code !== 2'b01) begin bad++; $display("FAIL illegal: got cyc=%0d st=%0d f=%b code=%b want 2 31 1 01", c, state_o, fault, fault_code); end
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (instr_count !== 4'd0 || mem_req !== 1'b0 || fault_code !== 2'b01) begin bad++; $display("FAIL illegal_hold: got cnt=%0d req=%b code=%b want 0 0 01", instr_count, mem_req, fault_code); end
    mem_ready = 1'b0;
    apply_reset();
  endtask

  task automatic test_wrap();
    int c, p, i, w, r, rw;
    for (int k = 0; k < 15; k++) exec(OP_J, 6'd0, 1'b0, 0, 0, c, p, i, w, r, rw);
    total++; if (instr_count !== 4'd15 || c != 3) begin bad++; $display("FAIL wrap_15: got cnt=%0d cyc=%0d want 15 3", instr_count, c); end
    exec(OP_J, 6'd0, 1'b0, 0, 0, c, p, i, w, r, rw);
    total++; if (instr_count !== 4'd0) begin bad++; $display("FAIL wrap_0: got cnt=%0d want 0", instr_count); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_fetch_wait();
    test_sw_wait();
    test_other_ops();
    test_reset_mid_wait();
    test_timeout();
    test_illegal();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
